// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder
//   Parametrised Kogge-Stone adder/subtractor with a configurable number of
//   prefix levels between pipeline registers and a valid/ready stream
//   interface. The whole pipeline stalls together, so latency is fixed at
//   2 + ceil(log2(WIDTH)/PIPE_EVERY) beats of forward progress.
//
// Parameters
//   WIDTH       operand width, power of two, 4..64
//   PIPE_EVERY  prefix levels per pipeline register, 1..log2(WIDTH)
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear of every in-flight valid bit
//   in_valid / in_ready   operand beat handshake
//   in_a, in_b            operands
//   in_ci                 carry-in (add only)
//   in_sub                1: A-B, 0: A+B+ci
//   out_valid / out_ready result beat handshake
//   out_sum, out_co       result and carry-out (not-borrow when subtracting)
//   out_ovf               two's-complement signed overflow
module pipelined_prefix_adder #(
  parameter int WIDTH      = 16,
  parameter int PIPE_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int LOG2W = $clog2(WIDTH);

  // g/p are the running group generate/propagate; p0 is the original
  // bitwise propagate needed for the final sum.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p0;
    logic             c0;
    logic             a_msb;
    logic             b_msb;
    logic             vld;
  } stage_t;

  logic stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k <= LOG2W; k++) begin : lvl
    stage_t src;

    if (k == 0) begin : g_prep
      stage_t           s0_q;
      logic [WIDTH-1:0] b_eff;
      logic             c0_eff;

      always_comb begin
        b_eff  = in_sub ? ~in_b : in_b;
        c0_eff = in_sub | in_ci;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s0_q <= '0;
        end else if (flush) begin
          s0_q.vld <= 1'b0;
        end else if (!stall) begin
          if (in_valid) begin
            s0_q.g     <= in_a & b_eff;
            s0_q.p     <= in_a ^ b_eff;
            s0_q.p0    <= in_a ^ b_eff;
            s0_q.c0    <= c0_eff;
            s0_q.a_msb <= in_a[WIDTH-1];
            s0_q.b_msb <= b_eff[WIDTH-1];
            s0_q.vld   <= 1'b1;
          end else begin
            s0_q.vld <= 1'b0;
          end
        end
      end

      assign src = s0_q;
    end else begin : g_level
      localparam int unsigned D = 1 << (k - 1);
      stage_t prv;
      stage_t cmb;

      assign prv = lvl[k-1].src;

      // Bits below D already span down to bit 0: a gray cell folds c0 in
      // and zeroes p, which makes any later fold of the same bit a no-op.
      always_comb begin
        cmb = prv;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (i >= D) begin
            cmb.g[i] = prv.g[i] | (prv.p[i] & prv.g[i-D]);
            cmb.p[i] = prv.p[i] & prv.p[i-D];
          end else begin
            cmb.g[i] = prv.g[i] | (prv.p[i] & prv.c0);
            cmb.p[i] = 1'b0;
          end
        end
      end

      if ((k % PIPE_EVERY == 0) || (k == LOG2W)) begin : g_reg
        stage_t r_q;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_q <= '0;
          end else if (flush) begin
            r_q.vld <= 1'b0;
          end else if (!stall) begin
            if (cmb.vld) r_q <= cmb;
            else         r_q.vld <= 1'b0;
          end
        end

        assign src = r_q;
      end else begin : g_comb
        assign src = cmb;
      end
    end
  end

  stage_t           fin;
  logic [WIDTH-1:0] gp;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;

  assign fin = lvl[LOG2W].src;

  // Upper-half bits whose partner was folded in the same last level still
  // carry a non-zero group propagate; one final gray row completes them.
  always_comb begin
    gp    = fin.g | (fin.p & {WIDTH{fin.c0}});
    carry = {gp[WIDTH-2:0], fin.c0};
    sum_d = fin.p0 ^ carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_co    <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= fin.vld;
      if (fin.vld) begin
        out_sum <= sum_d;
        out_co  <= gp[WIDTH-1];
        out_ovf <= (fin.a_msb == fin.b_msb) && (sum_d[WIDTH-1] != fin.a_msb);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb_pipelined_prefix_adder
//   Instance 0 (WIDTH=16, PIPE_EVERY=1) runs the directed scenarios: reset,
//   latency vectors, streaming with a stall window and flush. The remaining
//   instances sweep WIDTH 4/8/32/64 over every legal PIPE_EVERY with random
//   traffic and a mid-run asynchronous reset pulse. Every instance has its
//   own expectation queue and monitor.
module tb_pipelined_prefix_adder;

  localparam int NCFG = 17;

  function automatic int cfg_w(input int c);
    if (c == 0) return 16;
    if (c <= 2) return 4;
    if (c <= 5) return 8;
    if (c <= 10) return 32;
    return 64;
  endfunction

  function automatic int cfg_p(input int c);
    if (c == 0) return 1;
    if (c <= 2) return c;
    if (c <= 5) return c - 2;
    if (c <= 10) return c - 5;
    return c - 10;
  endfunction

  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        ovf;
    int          cyc;
    int          stl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [NCFG-1:0] done_vec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar c = 0; c < NCFG; c++) begin : cfg
    localparam int W   = cfg_w(c);
    localparam int PE  = cfg_p(c);
    localparam int LAT = 2 + ($clog2(W) + PE - 1) / PE;

    logic         rst_n     = 1'b0;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ci     = 1'b0;
    logic         in_sub    = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_co;
    logic         out_ovf;
    logic [W-1:0] out_sum;

    exp_t q[$];
    int   stall_cnt = 0;
    logic done      = 1'b0;

    assign done_vec[c] = done;

    pipelined_prefix_adder #(.WIDTH(W), .PIPE_EVERY(PE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_ci    (in_ci),
      .in_sub   (in_sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_co   (out_co),
      .out_ovf  (out_ovf)
    );

    // Reference: integer add/subtract; co is not-borrow (a >= b) for
    // subtract; ovf is "exact signed result does not fit in W bits".
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sub);
      exp_t         e;
      logic [W:0]   u;
      logic [W+1:0] sa;
      logic [W+1:0] sb;
      logic [W+1:0] s;
      sa = {{2{a[W-1]}}, a};
      sb = {{2{b[W-1]}}, b};
      if (sub) begin
        u    = {1'b0, a} - {1'b0, b};
        s    = sa - sb;
        e.co = (a >= b);
      end else begin
        u    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        s    = sa + sb + {{(W+1){1'b0}}, ci};
        e.co = u[W];
      end
      e.sum = 64'(u[W-1:0]);
      e.ovf = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
      e.cyc = 0;
      e.stl = 0;
      return e;
    endfunction

    function automatic logic [W-1:0] pick();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return {1'b0, {(W-1){1'b1}}};
        default: return r[W-1:0];
      endcase
    endfunction

    task automatic push(input exp_t e);
      e.cyc = cyc;
      e.stl = stall_cnt;
      q.push_back(e);
    endtask

    task automatic drain(input string tag);
      int n = 0;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("c%0d_%s_drained", c, tag), 64'(q.size()), 64'd0);
    endtask

    // Monitor: a result transfers on the next edge when valid && ready.
    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) begin
          if (out_valid && out_ready) begin
            chk($sformatf("c%0d_have_expect", c), 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
              e = q.pop_front();
              chk($sformatf("c%0d_sum", c), 64'(out_sum), e.sum);
              chk($sformatf("c%0d_co", c), 64'(out_co), 64'(e.co));
              chk($sformatf("c%0d_ovf", c), 64'(out_ovf), 64'(e.ovf));
              chk($sformatf("c%0d_latency", c), 64'(cyc),
                  64'(e.cyc + LAT + (stall_cnt - e.stl)));
            end
          end
          if (out_valid && !out_ready) stall_cnt++;
        end
      end
    end

    if (c == 0) begin : g_dir
      task automatic issue_const(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub,
                                 input logic [W-1:0] es, input logic eco, input logic eov);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_ci = ci; in_sub = sub;
        #1;
        chk("dir_issue_ready", 64'(in_ready), 64'd1);
        e.sum = 64'(es); e.co = eco; e.ovf = eov; e.cyc = 0; e.stl = 0;
        if (in_ready) push(e);
      endtask

      task automatic rand_beat();
        @(negedge clk);
        in_valid = 1'b1; in_a = pick(); in_b = pick();
        in_ci = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
      endtask

      initial begin
        int  base;
        int  sent;
        int  n;
        bit  need;
        bit  win;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_sum", 64'(out_sum), 64'd0);
        chk("reset_out_co", 64'(out_co), 64'd0);
        chk("reset_out_ovf", 64'(out_ovf), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        issue_const(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue_const(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue_const(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue_const(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        drain("latency");

        // Streaming: out_ready low for cycles 5..8 counted from the first
        // cycle a result is on the output.
        base = -1; sent = 0; n = 0; need = 1'b1;
        while ((sent < 20 || q.size() != 0) && n < 100) begin
          @(negedge clk);
          n++;
          if (base < 0 && out_valid) base = cyc;
          win = (base >= 0) && (cyc - base >= 5) && (cyc - base <= 8);
          out_ready = !win;
          if (sent < 20) begin
            if (need) begin
              in_a = pick(); in_b = pick();
              in_ci = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
              need = 1'b0;
            end
            in_valid = 1'b1;
          end else begin
            in_valid = 1'b0;
          end
          #1;
          chk("stream_in_ready", 64'(in_ready), 64'(!win));
          if (in_valid && in_ready) begin
            push(model(in_a, in_b, in_ci, in_sub));
            sent++;
            need = 1'b1;
          end
        end
        chk("stream_beats_sent", 64'(sent), 64'd20);
        out_ready = 1'b1;
        drain("stream");

        // Flush with four beats in flight and a same-cycle input beat.
        repeat (4) rand_beat();
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_a = pick();
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (12) @(negedge clk);
        rand_beat();
        #1;
        if (in_ready) push(model(in_a, in_b, in_ci, in_sub));
        @(negedge clk);
        in_valid = 1'b0;
        drain("flush_after");

        // Flush while the pipeline is stalled: flush wins over stall.
        out_ready = 1'b0;
        repeat (10) rand_beat();
        #1;
        chk("stalled_out_valid", 64'(out_valid), 64'd1);
        chk("stalled_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("stall_flush_out_valid", 64'(out_valid), 64'd0);
        chk("stall_flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        rand_beat();
        #1;
        if (in_ready) push(model(in_a, in_b, in_ci, in_sub));
        @(negedge clk);
        in_valid = 1'b0;
        drain("stall_flush_after");
        done = 1'b1;
      end
    end else begin : g_rnd
      initial begin
        int acc     = 0;
        int guard   = 0;
        bit did_rst = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        while (acc < 1000 && guard < 20000) begin
          @(negedge clk);
          guard++;
          in_valid  = ($urandom_range(0, 9) < 8);
          in_a      = pick();
          in_b      = pick();
          in_ci     = 1'($urandom_range(0, 1));
          in_sub    = 1'($urandom_range(0, 1));
          out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (in_valid && in_ready) begin
            push(model(in_a, in_b, in_ci, in_sub));
            acc++;
          end
          if (acc >= 500 && !did_rst) begin
            did_rst = 1'b1;
            #2;
            rst_n    = 1'b0;
            in_valid = 1'b0;
            #1;
            chk($sformatf("c%0d_async_rst_out_valid", c), 64'(out_valid), 64'd0);
            chk($sformatf("c%0d_async_rst_in_ready", c), 64'(in_ready), 64'd1);
            q.delete();
            rst_n = 1'b1;
          end
        end
        chk($sformatf("c%0d_beats_accepted", c), 64'(acc), 64'd1000);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("sweep");
        done = 1'b1;
      end
    end
  end

  initial begin
    int t = 0;
    while (done_vec !== {NCFG{1'b1}} && t < 60000) begin
      @(posedge clk);
      t++;
    end
    chk("all_configs_done", 64'(done_vec), 64'({NCFG{1'b1}}));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
